comparison_seq: RTL and testbench



---
 rtl/comparison_seq.sv | 130 +++++++++++++
 tb/tb_comparison_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/comparison_seq.sv
// comparison_seq
//   Two-stage pipelined comparison unit. Each accepted operand pair is compared
//   by the selected operation. The zero-extended result appears two cycles after
//   the pair is presented, together with a one-cycle valid strobe. Running
//   statistics are kept over the stream: the maximum of all operands seen, and a
//   saturating count of true comparisons.
//
//   Build option: define COMPARISON_SIGNED_EN to treat x, y, max and runMax as
//   two's-complement values. Without it every comparison is unsigned.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous clear of runMax/hitCount (wins over a same-cycle update)
//   inValid    operand pair valid this cycle
//   x, y       operands
//   operation  0 = x==y, 1 = x>y, 2 = x<y, 3 = max(x,y)
//   outValid   result valid strobe
//   result     comparison result, zero-extended to 2*WIDTH bits
//   runMax     running maximum of all operands since reset/clear
//   hitCount   saturating count of true results for operations 0-2
module comparison_seq #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   inValid,
  input  logic [WIDTH-1:0]       x,
  input  logic [WIDTH-1:0]       y,
  input  logic [1:0]             operation,
  output logic                   outValid,
  output logic [2*WIDTH-1:0]     result,
  output logic [WIDTH-1:0]       runMax,
  output logic [CNT_WIDTH-1:0]   hitCount
);

`ifdef COMPARISON_SIGNED_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return $signed(a) > $signed(b);
  endfunction
`else
  localparam logic [WIDTH-1:0] MIN_VAL = '0;

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return a > b;
  endfunction
`endif

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [1:0]       s1_op;

  logic             cmp_bool;
  logic [WIDTH-1:0] pair_max;
  logic [WIDTH-1:0] new_max;
  logic [2*WIDTH-1:0] cmp_word;
  logic             hit_inc;

  // Stage 1: data registers only move on an accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_op    <= '0;
    end else begin
      s1_valid <= inValid;
      if (inValid) begin
        s1_x  <= x;
        s1_y  <= y;
        s1_op <= operation;
      end
    end
  end

  always_comb begin
    // On a tie either operand is the max; y is picked arbitrarily.
    pair_max = greater(s1_x, s1_y) ? s1_x : s1_y;
    new_max  = greater(runMax, pair_max) ? runMax : pair_max;
    unique case (s1_op)
      2'd0:    cmp_bool = (s1_x == s1_y);
      2'd1:    cmp_bool = greater(s1_x, s1_y);
      2'd2:    cmp_bool = greater(s1_y, s1_x);
      default: cmp_bool = 1'b0;
    endcase
    if (s1_op == 2'd3) begin
      cmp_word = {{WIDTH{1'b0}}, pair_max};
    end else begin
      cmp_word = {{(2*WIDTH-1){1'b0}}, cmp_bool};
    end
    hit_inc = s1_valid && (s1_op != 2'd3) && cmp_bool && !(&hitCount);
  end

  // Stage 2: result holds its last value while no sample is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      result   <= '0;
    end else begin
      outValid <= s1_valid;
      if (s1_valid) begin
        result <= cmp_word;
      end
    end
  end

  // Statistics: clear discards a coincident stage-2 sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      runMax   <= MIN_VAL;
      hitCount <= '0;
    end else if (clear) begin
      runMax   <= MIN_VAL;
      hitCount <= '0;
    end else begin
      if (s1_valid) begin
        runMax <= new_max;
      end
      if (hit_inc) begin
        hitCount <= hitCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_comparison_seq.sv
module tb_comparison_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic [3:0] x;
  logic [3:0] y;
  logic [1:0] op;

  logic       out_valid;
  logic [7:0] result;
  logic [3:0] run_max;
  logic [7:0] hit;

  logic       out_valid_s;
  logic [7:0] result_s;
  logic [3:0] run_max_s;
  logic [1:0] hit_s;

  int tests = 0;
  int fails = 0;

`ifdef COMPARISON_SIGNED_EN
  localparam logic [3:0] MIN_VAL = 4'h8;
`else
  localparam logic [3:0] MIN_VAL = 4'h0;
`endif

  comparison_seq #(.WIDTH(4), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(in_valid),
    .x(x), .y(y), .operation(op),
    .outValid(out_valid), .result(result), .runMax(run_max), .hitCount(hit)
  );

  comparison_seq #(.WIDTH(4), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .inValid(in_valid),
    .x(x), .y(y), .operation(op),
    .outValid(out_valid_s), .result(result_s), .runMax(run_max_s), .hitCount(hit_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] op;
    logic [7:0] res;
    logic [3:0] rm;
    logic [7:0] hit;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] o);
    in_valid = v;
    x        = a;
    y        = b;
    op       = o;
  endtask

  function automatic logic [31:0] sat3(input logic [7:0] h);
    return (h > 8'd3) ? 32'd3 : {24'd0, h};
  endfunction

  initial begin
`ifdef COMPARISON_SIGNED_EN
    vecs[0] = '{4'h5, 4'h9, 2'd1, 8'h01, 4'h5, 8'd1};
    vecs[1] = '{4'h5, 4'h9, 2'd3, 8'h05, 4'h5, 8'd1};
    vecs[2] = '{4'h3, 4'h3, 2'd0, 8'h01, 4'h5, 8'd2};
    vecs[3] = '{4'h7, 4'h2, 2'd1, 8'h01, 4'h7, 8'd3};
    vecs[4] = '{4'h2, 4'h7, 2'd2, 8'h01, 4'h7, 8'd4};
    vecs[5] = '{4'hF, 4'h1, 2'd3, 8'h01, 4'h7, 8'd4};
    vecs[6] = '{4'hF, 4'h1, 2'd1, 8'h00, 4'h7, 8'd4};
    vecs[7] = '{4'h4, 4'h4, 2'd1, 8'h00, 4'h7, 8'd4};
    vecs[8] = '{4'h0, 4'hF, 2'd2, 8'h00, 4'h7, 8'd4};
    vecs[9] = '{4'hA, 4'h3, 2'd3, 8'h03, 4'h7, 8'd4};
`else
    vecs[0] = '{4'h5, 4'h9, 2'd1, 8'h00, 4'h9, 8'd0};
    vecs[1] = '{4'h5, 4'h9, 2'd3, 8'h09, 4'h9, 8'd0};
    vecs[2] = '{4'h3, 4'h3, 2'd0, 8'h01, 4'h9, 8'd1};
    vecs[3] = '{4'h7, 4'h2, 2'd1, 8'h01, 4'h9, 8'd2};
    vecs[4] = '{4'h2, 4'h7, 2'd2, 8'h01, 4'h9, 8'd3};
    vecs[5] = '{4'hF, 4'h1, 2'd3, 8'h0F, 4'hF, 8'd3};
    vecs[6] = '{4'hF, 4'h1, 2'd1, 8'h01, 4'hF, 8'd4};
    vecs[7] = '{4'h4, 4'h4, 2'd1, 8'h00, 4'hF, 8'd4};
    vecs[8] = '{4'h0, 4'hF, 2'd2, 8'h01, 4'hF, 8'd5};
    vecs[9] = '{4'hA, 4'h3, 2'd3, 8'h0A, 4'hF, 8'd5};
`endif

    rst_n = 1'b0;
    clear = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 2'd0);

    // Reset state
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", {24'd0, result}, 32'd0);
    check("reset_run_max", {28'd0, run_max}, {28'd0, MIN_VAL});
    check("reset_hit", {24'd0, hit}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back stream: pair driven at negedge i is checked at negedge i+2
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        check($sformatf("stream%0d_valid", i-2), {31'd0, out_valid}, 32'd1);
        check($sformatf("stream%0d_result", i-2), {24'd0, result}, {24'd0, vecs[i-2].res});
        check($sformatf("stream%0d_run_max", i-2), {28'd0, run_max}, {28'd0, vecs[i-2].rm});
        check($sformatf("stream%0d_hit", i-2), {24'd0, hit}, {24'd0, vecs[i-2].hit});
        check($sformatf("stream%0d_sat_valid", i-2), {31'd0, out_valid_s}, 32'd1);
        check($sformatf("stream%0d_sat_result", i-2), {24'd0, result_s}, {24'd0, vecs[i-2].res});
        check($sformatf("stream%0d_sat_run_max", i-2), {28'd0, run_max_s}, {28'd0, vecs[i-2].rm});
        check($sformatf("stream%0d_sat_hit", i-2), {30'd0, hit_s}, sat3(vecs[i-2].hit));
      end else begin
        check($sformatf("latency%0d_valid", i), {31'd0, out_valid}, 32'd0);
      end
      if (i < 10) drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].op);
      else        drive(1'b0, 4'h0, 4'h0, 2'd0);
    end
    @(negedge clk);
    check("stream_tail_valid", {31'd0, out_valid}, 32'd0);
    check("stream_tail_result_hold", {24'd0, result}, {24'd0, vecs[9].res});

    // Clear alone
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_run_max", {28'd0, run_max}, {28'd0, MIN_VAL});
    check("clear_hit", {24'd0, hit}, 32'd0);
    check("clear_result_kept", {24'd0, result}, {24'd0, vecs[9].res});

    // Saturation: five true equal compares
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check($sformatf("sat%0d_hit", k-1), {24'd0, hit}, k-1);
        check($sformatf("sat%0d_hit_sat", k-1), {30'd0, hit_s}, (k-1 > 3) ? 32'd3 : k-1);
        check($sformatf("sat%0d_run_max", k-1), {28'd0, run_max}, 32'd1);
      end
      if (k < 5) drive(1'b1, 4'h1, 4'h1, 2'd0);
      else       drive(1'b0, 4'h0, 4'h0, 2'd0);
    end

    // Clear coincident with a stage-2 true compare
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    drive(1'b1, 4'h5, 4'h5, 2'd0);
    @(negedge clk);
    drive(1'b1, 4'h3, 4'h3, 2'd0);
    @(negedge clk);
    check("pre_clear_valid", {31'd0, out_valid}, 32'd1);
    check("pre_clear_run_max", {28'd0, run_max}, 32'd5);
    check("pre_clear_hit", {24'd0, hit}, 32'd1);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("coincident_valid", {31'd0, out_valid}, 32'd1);
    check("coincident_result", {24'd0, result}, 32'h01);
    check("coincident_hit", {24'd0, hit}, 32'd0);
    check("coincident_run_max", {28'd0, run_max}, {28'd0, MIN_VAL});
    @(negedge clk);
    check("post_clear_valid", {31'd0, out_valid}, 32'd0);
    check("post_clear_hit", {24'd0, hit}, 32'd0);
    check("post_clear_run_max", {28'd0, run_max}, {28'd0, MIN_VAL});

    // Reset pulse while a pair is in flight
    drive(1'b1, 4'h9, 4'h9, 2'd0);
    @(negedge clk);
    drive(1'b1, 4'h6, 4'h6, 2'd0);
    @(negedge clk);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    check("pre_reset_run_max", {28'd0, run_max}, 32'h9);
    check("pre_reset_hit", {24'd0, hit}, 32'd1);
    drive(1'b0, 4'h0, 4'h0, 2'd0);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_result", {24'd0, result}, 32'd0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("flush%0d_valid", k), {31'd0, out_valid}, 32'd0);
      check($sformatf("flush%0d_result", k), {24'd0, result}, 32'd0);
      check($sformatf("flush%0d_run_max", k), {28'd0, run_max}, {28'd0, MIN_VAL});
      check($sformatf("flush%0d_hit", k), {24'd0, hit}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
